// File: rtl/mem_interface_unit.sv
// Memory interface stage: owns MAR/MDR and converts control-FSM strobes into a
// req/ack handshake with wait-state timeout and a sticky error flag.
module mem_interface_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              marce,
    input  logic              maroe,
    input  logic              mdrce,
    input  logic              mdroe,
    input  logic              mdrget,
    input  logic              mem_read,
    input  logic              mem_write,
    output logic              mem_busy,
    output logic              mem_done,
    output logic              mem_err,
    input  logic              err_clr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam int CNT_W = 8;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  mar_q, mar_d;
    logic [DATA_W-1:0]  mdr_q, mdr_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               rd_start, wr_start;
    logic [CNT_W-1:0]   cnt_inc;
    logic [ADDR_W-1:0]  start_addr;

    assign rd_start   = mem_read & maroe & mdrce & ~mem_write;
    assign wr_start   = mem_write & maroe & mdroe & ~mem_read;
    assign cnt_inc    = cnt_q + CNT_W'(1);
    // A same-cycle MAR load is forwarded straight to the request address.
    assign start_addr = marce ? bus_in[ADDR_W-1:0] : mar_q;

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (err_clr) err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (marce) mar_d = bus_in[ADDR_W-1:0];
                if (mdrce & ~mem_read) mdr_d = bus_in;
                if (mem_read & mem_write) begin
                    err_d = 1'b1;
                end else if (rd_start) begin
                    addr_d  = start_addr;
                    we_d    = 1'b0;
                    state_d = S_REQ;
                end else if (wr_start) begin
                    addr_d  = start_addr;
                    wdata_d = mdr_q;
                    we_d    = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    if (!we_q) mdr_d = mem_rdata;
                    state_d = S_DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // mem_req follows state so an async reset drops it immediately.
    assign mem_req   = (state_q == S_REQ);
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_busy  = (state_q != S_IDLE);
    assign mem_done  = (state_q == S_DONE);
    assign mem_err   = err_q;
    assign bus_out   = mdr_q;
    assign bus_oe    = mdroe & mdrget;

endmodule

// File: tb/tb_mem_interface_unit.sv
// Directed + randomized bench for mem_interface_unit against a transaction-level
// model of MAR/MDR contents and handshake timing.
module tb_mem_interface_unit;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              marce, maroe, mdrce, mdroe, mdrget;
    logic              mem_read, mem_write;
    logic              mem_busy, mem_done, mem_err, err_clr;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    int vectors = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] mar_m;
    logic [DATA_W-1:0] mdr_m;

    mem_interface_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .marce(marce), .maroe(maroe), .mdrce(mdrce), .mdroe(mdroe), .mdrget(mdrget),
        .mem_read(mem_read), .mem_write(mem_write), .mem_busy(mem_busy),
        .mem_done(mem_done), .mem_err(mem_err), .err_clr(err_clr), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        marce = 0; maroe = 0; mdrce = 0; mdroe = 0; mdrget = 0;
        mem_read = 0; mem_write = 0; err_clr = 0; mem_ack = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mar(input logic [15:0] v);
        marce = 1; bus_in = v;
        tick();
        clr();
        mar_m = v;
    endtask

    task automatic load_mdr(input logic [15:0] v);
        mdrce = 1; bus_in = v;
        tick();
        clr();
        mdr_m = v;
    endtask

    // Wait-state phase shared by reads and writes; returns with mem_done checked.
    task automatic wait_ack(input int waits, input logic is_read, input logic [15:0] rdata);
        for (int i = 0; i <= waits; i++) begin
            if (i < waits) begin
                // Strobes arriving while busy must not disturb MAR/MDR.
                mem_ack = 0; mem_read = 1; mdrce = 1; marce = 1;
                bus_in = 16'($urandom);
                mem_rdata = 16'($urandom);
                tick();
                chk1("req_hold", mem_req, 1'b1);
                chk1("done_early", mem_done, 1'b0);
                chk16("mdr_stable", bus_out, mdr_m);
            end else begin
                clr();
                mem_ack = 1; mem_rdata = rdata;
                tick();
                if (is_read) mdr_m = rdata;
                chk1("done_pulse", mem_done, 1'b1);
                chk1("req_drop", mem_req, 1'b0);
                chk1("busy_done", mem_busy, 1'b1);
                chk16("mdr_after", bus_out, mdr_m);
            end
        end
        clr();
        tick();
        chk1("done_single", mem_done, 1'b0);
        chk1("busy_idle", mem_busy, 1'b0);
    endtask

    task automatic do_read(input int waits, input logic [15:0] rdata);
        mem_read = 1; maroe = 1; mdrce = 1;
        tick();
        clr();
        chk1("rd_req", mem_req, 1'b1);
        chk1("rd_we", mem_we, 1'b0);
        chk16("rd_addr", mem_addr, mar_m);
        chk1("rd_busy", mem_busy, 1'b1);
        wait_ack(waits, 1'b1, rdata);
    endtask

    task automatic do_write(input int waits);
        mem_write = 1; maroe = 1; mdroe = 1;
        tick();
        clr();
        chk1("wr_req", mem_req, 1'b1);
        chk1("wr_we", mem_we, 1'b1);
        chk16("wr_addr", mem_addr, mar_m);
        chk16("wr_wdata", mem_wdata, mdr_m);
        wait_ack(waits, 1'b0, 16'($urandom));
    endtask

    initial begin
        bus_in = 0; mem_rdata = 0;
        clr();
        mar_m = 0; mdr_m = 0;

        // Reset with random strobe activity
        rst_n = 0;
        for (int i = 0; i < 3; i++) begin
            {marce, maroe, mdrce, mdroe, mem_read, mem_write, err_clr, mem_ack} = 8'($urandom);
            mdrget = 0;
            bus_in = 16'($urandom);
            tick();
        end
        chk1("rst_req", mem_req, 1'b0);
        chk1("rst_busy", mem_busy, 1'b0);
        chk1("rst_done", mem_done, 1'b0);
        chk1("rst_err", mem_err, 1'b0);
        chk1("rst_we", mem_we, 1'b0);
        chk1("rst_oe", bus_oe, 1'b0);
        chk16("rst_addr", mem_addr, 16'h0);
        chk16("rst_wdata", mem_wdata, 16'h0);
        chk16("rst_mdr", bus_out, 16'h0);
        clr();
        @(negedge clk);
        rst_n = 1;
        tick();

        // Bus path
        load_mar(16'h0040);
        load_mdr(16'hBEEF);
        mdroe = 1; mdrget = 1;
        #1;
        chk16("bus_out", bus_out, 16'hBEEF);
        chk1("bus_oe", bus_oe, 1'b1);
        tick();
        chk1("bus_noreq", mem_req, 1'b0);
        clr();
        #1;
        chk1("bus_oe_off", bus_oe, 1'b0);

        // Read with 3 wait states, then zero-wait write back-to-back
        do_read(3, 16'h1234);
        chk16("rd_mdr", bus_out, 16'h1234);
        load_mdr(16'hA5A5);
        load_mar(16'h0007);
        do_write(0);

        // Unqualified read: nothing happens
        mem_read = 1;
        tick();
        clr();
        chk1("unq_req", mem_req, 1'b0);
        chk1("unq_err", mem_err, 1'b0);

        // Timeout
        do_read_timeout();

        // Conflict, then set-wins over clear
        mem_read = 1; mem_write = 1; maroe = 1; mdrce = 1; mdroe = 1;
        bus_in = 16'hDEAD;
        tick();
        clr();
        chk1("cfl_err", mem_err, 1'b1);
        chk1("cfl_req", mem_req, 1'b0);
        chk1("cfl_busy", mem_busy, 1'b0);
        chk16("cfl_mdr", bus_out, mdr_m);
        mem_read = 1; mem_write = 1; err_clr = 1;
        tick();
        clr();
        chk1("cfl_setwins", mem_err, 1'b1);
        err_clr = 1;
        tick();
        clr();
        chk1("cfl_clr", mem_err, 1'b0);

        // Reset in the 2nd REQ cycle
        load_mar(16'h0123);
        mem_read = 1; maroe = 1; mdrce = 1;
        tick();
        clr();
        tick();
        chk1("mid_req_pre", mem_req, 1'b1);
        #2 rst_n = 0;
        #1;
        chk1("mid_req_async", mem_req, 1'b0);
        chk1("mid_busy_async", mem_busy, 1'b0);
        mar_m = 0; mdr_m = 0;
        @(negedge clk);
        rst_n = 1;
        mem_ack = 1; mem_rdata = 16'hFFFF;
        tick();
        chk1("late_ack_done", mem_done, 1'b0);
        chk1("late_ack_req", mem_req, 1'b0);
        chk16("late_ack_mdr", bus_out, 16'h0);
        clr();
        load_mar(16'h0055);
        do_read(1, 16'h5AA5);

        // Randomized transactions
        for (int n = 0; n < 25; n++) begin
            logic [15:0] a, d;
            int w;
            a = 16'($urandom);
            d = 16'($urandom);
            w = int'($urandom_range(0, 5));
            load_mar(a);
            if ($urandom_range(0, 1) == 1) begin
                load_mdr(d);
                do_write(w);
            end else begin
                do_read(w, d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    task automatic do_read_timeout();
        logic [15:0] keep;
        keep = mdr_m;
        mem_read = 1; maroe = 1; mdrce = 1;
        tick();
        clr();
        for (int i = 1; i < TIMEOUT; i++) begin
            tick();
            chk1("to_wait_err", mem_err, 1'b0);
        end
        chk1("to_wait_req", mem_req, 1'b1);
        tick();
        chk1("to_err", mem_err, 1'b1);
        chk1("to_req", mem_req, 1'b0);
        chk1("to_busy", mem_busy, 1'b1);
        chk1("to_nodone", mem_done, 1'b0);
        chk16("to_mdr", bus_out, keep);
        tick();
        chk1("to_busy_off", mem_busy, 1'b0);
        err_clr = 1;
        tick();
        clr();
        chk1("to_clr", mem_err, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_interface_unit.md
# mem_interface_unit

Memory interface stage sitting directly downstream of the processor control FSM. It owns the MAR and MDR registers and turns the FSM's one-cycle strobes (`marce`, `maroe`, `mdrce`, `mdroe`, `mdrget`, `mem_read`, `mem_write`) into a req/ack handshake with external instruction/data memory. It returns MDR contents onto the internal 16-bit datapath bus and raises `mem_busy` so the control FSM can stall while an access is in flight.

## Interface
- `DATA_W`, 16: datapath and memory word width.
- `ADDR_W`, 16: MAR/memory address width; MAR takes `bus_in[ADDR_W-1:0]`.
- `TIMEOUT`, 15: maximum `mem_req` cycles without `mem_ack` before error (1..255).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `bus_in`  in  DATA_W  internal datapath bus value.
- `bus_out`  out  DATA_W  MDR value presented to the bus.
- `bus_oe`  out  1  `bus_out` valid/drive enable.
- `marce`  in  1  load MAR from `bus_in`.
- `maroe`  in  1  MAR drives the memory address; qualifies `mem_read` and `mem_write`.
- `mdrce`  in  1  MDR load enable.
- `mdroe`  in  1  MDR output enable.
- `mdrget`  in  1  route MDR to the datapath bus; used with `mdroe`.
- `mem_read`  in  1  read request strobe.
- `mem_write`  in  1  write request strobe.
- `mem_busy`  out  1  transaction in flight; FSM must hold.
- `mem_done`  out  1  one-cycle completion pulse.
- `mem_err`  out  1  sticky error flag.
- `err_clr`  in  1  clears `mem_err`.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W  request address, registered.
- `mem_wdata`  out  DATA_W  write data, registered.
- `mem_rdata`  in  DATA_W  read data; valid when `mem_ack` is high.
- `mem_ack`  in  1  memory completion; sampled only while `mem_req` is high.

## Operation
- States: IDLE, REQ, DONE, ERR.
- Strobes are accepted only in IDLE. In REQ, DONE or ERR, `marce`, `mdrce`, `mem_read` and `mem_write` are ignored, so MAR and MDR stay stable.
- IDLE, `marce`: MAR <= `bus_in`.
- IDLE, `mdrce & ~mem_read`: MDR <= `bus_in` (store-data path).
- IDLE, read start (`mem_read & maroe & mdrce & ~mem_write`):
  - `mem_addr` <= (`marce` ? `bus_in` : MAR).
  - `mem_we` <= 0; go to REQ.
- IDLE, write start (`mem_write & maroe & mdroe & ~mem_read`):
  - `mem_addr` <= (`marce` ? `bus_in` : MAR).
  - `mem_wdata` <= MDR; `mem_we` <= 1; go to REQ.
- IDLE, `mem_read & mem_write` together: no transaction; `mem_err` <= 1; stay in IDLE.
- IDLE, `mem_read` or `mem_write` without its qualifiers: no transaction, no error.
- REQ: `mem_req` = 1; the wait counter increments each cycle.
  - `mem_ack`: on a read, MDR <= `mem_rdata`; go to DONE.
  - Counter reaches TIMEOUT without ack: `mem_err` <= 1; MDR unchanged; go to ERR.
- DONE: `mem_done` = 1 for one cycle; go to IDLE.
- ERR: one cycle, `mem_done` = 0; go to IDLE.
- `mem_busy` = (state != IDLE).
- `bus_oe` = `mdroe & mdrget` in any state; `bus_out` = MDR always.
- `err_clr` clears `mem_err`. If a set condition occurs in the same cycle, set wins.
- Reset values: state IDLE; MAR, MDR, `mem_addr`, `mem_wdata` = 0; counter = 0; `mem_req`, `mem_we`, `mem_busy`, `mem_done`, `mem_err`, `bus_oe` = 0 (`bus_oe` is 0 provided the strobes are low).
- Reset asserted mid-REQ: `mem_req` drops asynchronously and the transaction is abandoned; a late `mem_ack` after reset is ignored.

## Timing
- Start strobe sampled at edge N; `mem_req`, `mem_addr`, `mem_we` valid after N; `mem_busy` high after N.
- `mem_ack` sampled high at edge M: read data is in MDR after M, `mem_req` is low after M, and `mem_done` is high during M..M+1.
- After M+1, `mem_busy` = 0 and the next start is accepted at edge M+2.
- Zero-wait memory (ack in the first REQ cycle): 2 cycles from start edge to `mem_done`; 3 cycles to the next accepted start.
- Timeout: `mem_err` is high after edge N+TIMEOUT; `mem_busy` falls one cycle later.
- `bus_out`/`bus_oe` are combinational from MDR and the strobes. MDR loaded at edge K is visible on `bus_out` in the cycle after K.

## Test plan
- Reset: drive `rst_n` = 0 with random strobes → all outputs 0, MAR = MDR = 0.
- Bus path: `marce`, `bus_in` = 16'h0040; then `mdrce`, `bus_in` = 16'hBEEF; then `mdroe & mdrget` → `bus_out` = 16'hBEEF, `bus_oe` = 1, no `mem_req`.
- Read with 3 wait cycles: MAR = 16'h0040, read start, `mem_ack` on the 4th REQ cycle with `mem_rdata` = 16'h1234 → `mem_addr` = 16'h0040, `mem_we` = 0, MDR = 16'h1234, single `mem_done`; `mem_read` pulsed during busy is ignored.
- Write with zero wait: MDR = 16'hA5A5, MAR = 16'h0007, write start, immediate ack → `mem_we` = 1, `mem_wdata` = 16'hA5A5, `mem_addr` = 16'h0007, `mem_done` 2 cycles after start.
- Timeout and conflict: no ack for TIMEOUT = 15 cycles → `mem_err` = 1 and MDR unchanged; `err_clr` clears it. `mem_read` and `mem_write` together → `mem_err` = 1 with no `mem_req`.
- Reset mid-REQ: deassert `rst_n` in the 2nd REQ cycle → `mem_req` = 0 immediately. After release, an ack is ignored, `mem_done` stays 0, and a new read completes normally.
